// File: rtl/lsu_bus_master.sv
// Load/store unit between execute and writeback: one req/ack data-memory
// transaction per instruction, with lane steering, load extension, misalignment and timeout errors.
//
// state  | meaning
// IDLE   | waiting for a request from execute
// ACCESS | bus_req high, waiting for bus_ack or timeout
// DONE   | one-cycle completion pulse, lsu_rdata valid
// ERR    | one-cycle completion pulse with err, lsu_rdata = 0
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] lsu_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_byte;
    logic        req_half;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;
    logic [15:0] cnt_inc;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Request decode; reserved size 11 behaves as a word.
    always_comb begin
        req_byte       = (req_size == 2'b00);
        req_half       = (req_size == 2'b01);
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
        if (req_byte) begin
            req_be         = 4'b0001 << req_addr[1:0];
            req_lane_wdata = {4{req_wdata[7:0]}};
        end else if (req_half) begin
            req_misaligned = req_addr[0];
            req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
            req_lane_wdata = {2{req_wdata[15:0]}};
        end else begin
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
        if (!req_we) begin
            req_lane_wdata = 32'h0;
        end
    end

    always_comb begin
        ld_byte  = bus_rdata[{off_q, 3'b000} +: 8];
        ld_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_value = bus_rdata;
        if (size_q == 2'b00) begin
            ld_value = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_q == 2'b01) begin
            ld_value = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        state_d = S_ERR;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = S_ACCESS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_lane_wdata;
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        off_d       = req_addr[1:0];
                        cnt_d       = 16'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    rdata_d   = bus_we_q ? 32'h0 : ld_value;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        state_d   = S_ERR;
                        bus_req_d = 1'b0;
                        rdata_d   = 32'h0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            cnt_q       <= 16'd0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    assign stall     = ((state_q == S_IDLE) && req_valid) || (state_q == S_ACCESS);
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);
    assign lsu_rdata = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: default-timeout instance for the data path,
// a TIMEOUT_CYCLES = 4 instance with its ack tied low for the timeout case.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        stall, done, err, bus_req, bus_we;
    logic [31:0] lsu_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        t_stall, t_done, t_err, t_bus_req, t_bus_we;
    logic [31:0] t_lsu_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .done(done), .err(err),
        .lsu_rdata(lsu_rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(t_stall), .done(t_done), .err(t_err),
        .lsu_rdata(t_lsu_rdata), .bus_req(t_bus_req), .bus_we(t_bus_we),
        .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
        .bus_ack(1'b0), .bus_rdata(bus_rdata)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        bus_ack      = 1'b0;
        bus_rdata    = 32'h0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_bus_we: got %b want 0", bus_we); end
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
        n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_checks++; if (bus_be !== 4'h0) begin n_fail++; $display("FAIL reset_bus_be: got %b want 0000", bus_be); end
        n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
        n_checks++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_lsu_rdata: got %h want 0", lsu_rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_word_load();
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'hFFFF_FFFF);
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wl_c0_stall: got %b want 1", stall); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL wl_c0_bus_req: got %b want 0", bus_req); end
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL wl_c1_bus_req: got %b want 1", bus_req); end
        n_checks++; if (bus_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL wl_bus_addr: got %h want 00001004", bus_addr); end
        n_checks++; if (bus_be !== 4'b1111) begin n_fail++; $display("FAIL wl_bus_be: got %b want 1111", bus_be); end
        n_checks++; if ({bus_we, bus_wdata} !== 33'h0) begin n_fail++; $display("FAIL wl_we_wdata: got %b/%h want 0/0", bus_we, bus_wdata); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wl_c1_stall: got %b want 1", stall); end
        next_cycle();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        @(negedge clk);
        n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL wl_c2_done_err: got %b want 10", {done, err}); end
        n_checks++; if (lsu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wl_lsu_rdata: got %h want deadbeef", lsu_rdata); end
        n_checks++; if ({stall, bus_req} !== 2'b00) begin n_fail++; $display("FAIL wl_c2_stall_req: got %b want 00", {stall, bus_req}); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, bus_req, stall} !== 3'b000) begin n_fail++; $display("FAIL wl_c3_idle: got %b want 000", {done, bus_req, stall}); end
    endtask

    task automatic test_misaligned();
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
        @(negedge clk);
        n_checks++; if ({stall, bus_req} !== 2'b10) begin n_fail++; $display("FAIL mis_c0_stall_req: got %b want 10", {stall, bus_req}); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({done, err} !== 2'b11) begin n_fail++; $display("FAIL mis_done_err: got %b want 11", {done, err}); end
        n_checks++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_lsu_rdata: got %h want 0", lsu_rdata); end
        n_checks++; if ({bus_req, stall} !== 2'b00) begin n_fail++; $display("FAIL mis_c1_req_stall: got %b want 00", {bus_req, stall}); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, err, bus_req} !== 3'b000) begin n_fail++; $display("FAIL mis_c2_idle: got %b want 000", {done, err, bus_req}); end
    endtask

    task automatic test_byte_load(input logic uns, input logic [31:0] exp);
        next_cycle();
        drive_req(1'b0, 2'b00, uns, 32'h0000_2003, 32'h0);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'h80AA_BBCC;
        @(negedge clk);
        n_checks++; if (bus_be !== 4'b1000) begin n_fail++; $display("FAIL bl_bus_be: got %b want 1000", bus_be); end
        n_checks++; if (bus_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL bl_bus_addr: got %h want 00002000", bus_addr); end
        next_cycle();
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bl_done: got %b want 1", done); end
        n_checks++; if (lsu_rdata !== exp) begin n_fail++; $display("FAIL bl_lsu_rdata uns=%b: got %h want %h", uns, lsu_rdata, exp); end
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic test_half_store();
        next_cycle();
        drive_req(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1234_5678);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            bus_ack = (i == 4);
            @(negedge clk);
            n_checks++; if ({bus_req, bus_we} !== 2'b11) begin n_fail++; $display("FAIL hs_c%0d_req_we: got %b want 11", i, {bus_req, bus_we}); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL hs_c%0d_done: got %b want 0", i, done); end
        end
        n_checks++; if (bus_be !== 4'b1100) begin n_fail++; $display("FAIL hs_bus_be: got %b want 1100", bus_be); end
        n_checks++; if (bus_wdata !== 32'h5678_5678) begin n_fail++; $display("FAIL hs_bus_wdata: got %h want 56785678", bus_wdata); end
        n_checks++; if (bus_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL hs_bus_addr: got %h want 00003000", bus_addr); end
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, err, bus_req} !== 3'b100) begin n_fail++; $display("FAIL hs_done: got %b want 100", {done, err, bus_req}); end
        n_checks++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL hs_lsu_rdata: got %h want 0", lsu_rdata); end
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_5A00;
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (lsu_rdata !== 32'h0000_5A00) begin n_fail++; $display("FAIL b2b_first_rdata: got %h want 00005a00", lsu_rdata); end
        next_cycle();
        drive_req(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0);
        @(negedge clk);
        n_checks++; if ({stall, bus_req, done} !== 3'b100) begin n_fail++; $display("FAIL b2b_accept: got %b want 100", {stall, bus_req, done}); end
        next_cycle();
        bus_ack = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus_req, bus_be} !== 5'b1_0010) begin n_fail++; $display("FAIL b2b_req_be: got %b want 10010", {bus_req, bus_be}); end
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, lsu_rdata} !== {1'b1, 32'h0000_005A}) begin n_fail++; $display("FAIL b2b_second: got %b/%h want 1/0000005a", done, lsu_rdata); end
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        n_checks++; if (t_bus_req !== 1'b0) begin n_fail++; $display("FAIL to_c0_bus_req: got %b want 0", t_bus_req); end
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            @(negedge clk);
            n_checks++; if ({t_bus_req, t_done} !== 2'b10) begin n_fail++; $display("FAIL to_c%0d_req_done: got %b want 10", i, {t_bus_req, t_done}); end
        end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({t_bus_req, t_done, t_err} !== 3'b011) begin n_fail++; $display("FAIL to_err_pulse: got %b want 011", {t_bus_req, t_done, t_err}); end
        n_checks++; if (t_lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_lsu_rdata: got %h want 0", t_lsu_rdata); end
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({t_done, t_err, t_bus_req, t_stall} !== 4'b0000) begin n_fail++; $display("FAIL to_idle: got %b want 0000", {t_done, t_err, t_bus_req, t_stall}); end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rma_pre_req: got %b want 1", bus_req); end
        next_cycle();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rma_async_drop: got %b want 0", bus_req); end
        next_cycle();
        rst_n     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        @(negedge clk);
        n_checks++; if ({bus_req, done, err} !== 3'b000) begin n_fail++; $display("FAIL rma_late_ack: got %b want 000", {bus_req, done, err}); end
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus_req, done, err, lsu_rdata} !== 35'h0) begin n_fail++; $display("FAIL rma_after_ack: got %b/%h want 000/0", {bus_req, done, err}, lsu_rdata); end
        next_cycle();
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0084}) begin n_fail++; $display("FAIL rma_next_req: got %b/%h want 1/00000084", bus_req, bus_addr); end
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({done, err, lsu_rdata} !== {2'b10, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL rma_next_done: got %b/%h want 10/cafef00d", {done, err}, lsu_rdata); end
        next_cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_misaligned();
        test_byte_load(1'b0, 32'hFFFF_FF80);
        test_byte_load(1'b1, 32'h0000_0080);
        test_half_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
